// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter:
//   - arb_state_e : arbiter state encoding (IDLE, GRANT, LOCKED)
//   - DEF_*       : default widths and limits used as parameter defaults
//   - rr_index    : rotate-priority helper returning (base + offset) mod n
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LOCK_MAX   = 8;
  localparam int LOCK_CNT_W     = 8;

  // Position of the offset-th candidate when priority starts at base.
  // Both base and offset are below n, so one conditional subtract is
  // enough and no divider is built.
  function automatic int rr_index(input int base, input int offset, input int n);
    int s;
    s = base + offset;
    if (s >= n) begin
      s = s - n;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin picker. Scans req starting at ptr, wrapping
//   modulo N, and returns the first asserted request.
//   Ports:
//     req        in  N   request vector
//     ptr        in  PW  index with highest priority this round
//     winner     out N   one-hot winner (all zero when no request)
//     winner_idx out PW  binary index of the winner
//     valid      out 1   at least one request was asserted
module rr_priority_pick
  import mem_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx,
  output logic          valid
);

  logic [PW-1:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'(rr_index(int'(ptr), k, N));
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        winner_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one port of a dual-port memory between NUM_REQ requesters with
//   registered round-robin arbitration and an optional bounded lock for
//   read-modify-write sequences. One access is issued per cycle; each
//   access is answered by a one-cycle rsp_valid strobe in the next cycle.
//   Ports:
//     clock            in   rising edge used here; memory uses falling edge
//     reset            in   synchronous, active low
//     req/req_we/req_lock in NUM_REQ  per-requester request, write, lock
//     req_addr         in   flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//     req_wdata        in   flattened, same packing as req_addr
//     gnt              out  one-hot, access issued this cycle
//     rsp_valid        out  one-hot, access issued last cycle has completed
//     rsp_rdata        out  read data (write data for writes), from memory
//     mem_address/mem_write_data/mem_write_enable out  memory port pins
//     mem_read_data    in   memory port read data
//     dbg_state        out  current arbiter state, for observation
//
//   Handshake: a requester raises req with addr/wdata/we stable. A rising
//   edge at which req is high and the requester wins issues the access;
//   gnt is high for the cycle that follows that edge, and the requester
//   may change or drop its request before the edge that ends the gnt
//   cycle. A request still high at that edge counts as a new access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic                          mem_write_enable,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  output arb_state_e                    dbg_state
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         owner_q, owner_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    rsp_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;

  logic [NUM_REQ-1:0]    win_oh;
  logic [PW-1:0]         win_idx;
  logic                  win_valid;
  logic [PW-1:0]         sel_idx;
  logic                  owner_keeps;
  logic                  forced_release;
  logic                  lock_honoured;

  rr_priority_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .winner     (win_oh),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  // While locked, the owner alone is served as long as it keeps both req
  // and req_lock up and has not used up its LOCK_MAX grants. Otherwise the
  // same edge falls back to round-robin from the frozen pointer.
  always_comb begin
    owner_keeps    = (state_q == LOCKED) && req[owner_q] && req_lock[owner_q] &&
                     (lock_cnt_q < LOCK_CNT_W'(LOCK_MAX));
    forced_release = (state_q == LOCKED) && (lock_cnt_q >= LOCK_CNT_W'(LOCK_MAX));
    // A forced release ignores req_lock for this one round so the pointer
    // moves on even if the owner immediately wins again.
    lock_honoured  = win_valid && req_lock[win_idx] && !forced_release;
    sel_idx        = owner_keeps ? owner_q : win_idx;
  end

  // Next-state and registered-output logic. The state after a grant is the
  // state the next arbitration runs in: a locking grant moves straight to
  // LOCKED so the following edge is owner-only.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    gnt_d      = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;

    if (owner_keeps || win_valid) begin
      addr_d  = req_addr[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d = req_wdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
      we_d    = req_we[sel_idx];
    end

    if (owner_keeps) begin
      gnt_d[owner_q] = 1'b1;
      lock_cnt_d     = lock_cnt_q + 1'b1;
      state_d        = LOCKED;
    end else if (win_valid) begin
      gnt_d = win_oh;
      ptr_d = PW'(rr_index(int'(win_idx), 1, NUM_REQ));
      if (lock_honoured) begin
        state_d    = LOCKED;
        owner_d    = win_idx;
        lock_cnt_d = LOCK_CNT_W'(1);
      end else begin
        state_d    = GRANT;
        lock_cnt_d = '0;
      end
    end else begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      gnt_q      <= '0;
      rsp_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
      rsp_q      <= gnt_q;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  assign gnt            = gnt_q;
  assign rsp_valid      = rsp_q;
  assign rsp_rdata      = mem_read_data;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  // Reset is also applied combinationally so the memory never sees a write
  // during a cycle in which reset is held low, even mid-cycle.
  assign mem_write_enable = we_q & reset;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter (NUM_REQ=4, LOCK_MAX=3). Every
//   clock edge is driven through tick(), which pushes the expected outputs
//   for the cycle after that edge into exp_q; a monitor pops one entry per
//   falling edge and compares. A behavioural memory drives mem_read_data.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset;
  logic [NR-1:0]        req, req_we, req_lock;
  logic [NR*AW-1:0]     req_addr;
  logic [NR*DW-1:0]     req_wdata;
  logic [NR-1:0]        gnt, rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic [AW-1:0]        mem_address;
  logic [DW-1:0]        mem_write_data;
  logic                 mem_write_enable;
  logic [DW-1:0]        mem_read_data = '0;
  arb_state_e           dbg_state;

  mem_port_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(3)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  // Captures on the falling edge of the grant cycle, presents the word
  // from the next rising edge (held for the whole response cycle).
  // Unwritten words read as address ^ 16'h5A5A; writes pass through.
  logic [DW-1:0] mem_arr [logic [AW-1:0]];
  logic [DW-1:0] rd_next = '0;

  always @(negedge clock) begin
    if (mem_write_enable) begin
      mem_arr[mem_address] = mem_write_data;
      rd_next = mem_write_data;
    end else if (mem_arr.exists(mem_address)) begin
      rd_next = mem_arr[mem_address];
    end else begin
      rd_next = mem_address ^ 16'h5A5A;
    end
  end

  always @(posedge clock) mem_read_data <= rd_next;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
    logic [NR-1:0] rsp;
    logic [DW-1:0] rdata;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected-value model state, owned by the driver.
  logic [AW-1:0] a [NR];
  logic [DW-1:0] d [NR];
  logic [DW-1:0] shadow [logic [AW-1:0]];
  logic [NR-1:0] prev_gnt   = '0;
  logic [DW-1:0] prev_rdata = '0;
  logic [AW-1:0] last_addr  = '0;
  logic [DW-1:0] last_wdata = '0;

  function automatic logic [DW-1:0] shadow_rd(input logic [AW-1:0] ad);
    if (shadow.exists(ad)) return shadow[ad];
    return ad ^ 16'h5A5A;
  endfunction

  // ---------------- driver ----------------
  // win is the hand-computed winner for this edge, or -1 for no grant.
  task automatic tick(input logic rst_n, input logic [NR-1:0] r,
                      input logic [NR-1:0] w, input logic [NR-1:0] l,
                      input int win);
    exp_t e;
    reset    = rst_n;
    req      = r;
    req_we   = w;
    req_lock = l;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = a[i];
      req_wdata[i*DW +: DW] = d[i];
    end
    e.rsp   = prev_gnt;
    e.rdata = prev_rdata;
    if (!rst_n) begin
      e.gnt = '0; e.addr = '0; e.wdata = '0; e.we = 1'b0; e.rsp = '0; e.rdata = '0;
      last_addr = '0; last_wdata = '0; prev_gnt = '0;
    end else if (win >= 0) begin
      e.gnt   = NR'(1) << win;
      e.addr  = a[win];
      e.wdata = d[win];
      e.we    = w[win];
      last_addr  = a[win];
      last_wdata = d[win];
      prev_gnt   = e.gnt;
      if (w[win]) begin
        shadow[a[win]] = d[win];
        prev_rdata     = d[win];
      end else begin
        prev_rdata = shadow_rd(a[win]);
      end
    end else begin
      e.gnt = '0; e.addr = last_addr; e.wdata = last_wdata; e.we = 1'b0;
      prev_gnt = '0;
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    @(posedge clock);
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_t'(exp_q.pop_front());
        chk("gnt", 32'(gnt), 32'(e.gnt));
        chk("mem_address", 32'(mem_address), 32'(e.addr));
        chk("mem_write_data", 32'(mem_write_data), 32'(e.wdata));
        chk("mem_write_enable", 32'(mem_write_enable), 32'(e.we));
        chk("rsp_valid", 32'(rsp_valid), 32'(e.rsp));
        if (e.rsp != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NR; i++) begin
      a[i] = 16'h1000 + 16'(i);
      d[i] = 16'hA000 + 16'(i);
    end
    reset = 1'b0; req = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;

    // Reset held with all requesting: nothing granted, no writes.
    repeat (3) tick(1'b0, 4'b1111, 4'b0000, 4'b0000, -1);
    chk("state_in_reset", 32'(dbg_state), 32'(IDLE));

    // Release, then fairness: 0,1,2,3,0.
    tick(1'b1, 4'b1111, 4'b0000, 4'b0000, 0);
    tick(1'b1, 4'b1111, 4'b0000, 4'b0000, 1);
    tick(1'b1, 4'b1111, 4'b0000, 4'b0000, 2);
    tick(1'b1, 4'b1111, 4'b0000, 4'b0000, 3);
    tick(1'b1, 4'b1111, 4'b0000, 4'b0000, 0);
    tick(1'b1, 4'b0000, 4'b0000, 4'b0000, -1);

    // Write 0xBEEF to 0x0123 by req0, read back by req1 (pointer at 1).
    a[0] = 16'h0123; d[0] = 16'hBEEF;
    tick(1'b1, 4'b0001, 4'b0001, 4'b0000, 0);
    a[1] = 16'h0123;
    tick(1'b1, 4'b0010, 4'b0000, 4'b0000, 1);

    // Lock by req2 with req0 competing, LOCK_MAX=3 (pointer at 2).
    tick(1'b1, 4'b0101, 4'b0000, 4'b0100, 2);
    chk("state_locked", 32'(dbg_state), 32'(LOCKED));
    tick(1'b1, 4'b0101, 4'b0000, 4'b0100, 2);
    tick(1'b1, 4'b0101, 4'b0000, 4'b0100, 2);
    tick(1'b1, 4'b0101, 4'b0000, 4'b0100, 0);  // forced release
    tick(1'b1, 4'b0101, 4'b0000, 4'b0100, 2);  // relocks, pointer frozen at 3
    tick(1'b1, 4'b0101, 4'b0000, 4'b0000, 0);  // owner drops lock

    // Both lock: only winner 1 honoured; owner then drops req.
    tick(1'b1, 4'b0011, 4'b0000, 4'b0011, 1);
    tick(1'b1, 4'b0011, 4'b0000, 4'b0011, 1);
    tick(1'b1, 4'b0001, 4'b0000, 4'b0001, 0);  // round-robin from 2 -> 0
    tick(1'b1, 4'b0000, 4'b0000, 4'b0000, -1);

    // Reset right after a read grant to req1: response dropped.
    tick(1'b1, 4'b0010, 4'b0000, 4'b0000, 1);
    tick(1'b0, 4'b1111, 4'b0000, 4'b0000, -1);
    tick(1'b0, 4'b1111, 4'b0000, 4'b0000, -1);
    tick(1'b1, 4'b1111, 4'b0000, 4'b0000, 0);  // pointer restarted at 0

    // Idle hold after a read of 0x00FF by req3.
    a[3] = 16'h00FF;
    tick(1'b1, 4'b1000, 4'b0000, 4'b0000, 3);
    tick(1'b1, 4'b0000, 4'b0000, 4'b0000, -1);
    tick(1'b1, 4'b0000, 4'b0000, 4'b0000, -1);

    // Back-to-back grants to a lone requester.
    a[2] = 16'h0200; d[2] = 16'h1234;
    tick(1'b1, 4'b0100, 4'b0100, 4'b0000, 2);
    d[2] = 16'h5678;
    tick(1'b1, 4'b0100, 4'b0100, 4'b0000, 2);
    tick(1'b1, 4'b0100, 4'b0000, 4'b0000, 2);
    tick(1'b1, 4'b0000, 4'b0000, 4'b0000, -1);
    tick(1'b1, 4'b0000, 4'b0000, 4'b0000, -1);

    // Let the monitor drain the queue, bounded.
    repeat (3) @(posedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
